// File: rtl/score_digit_sequencer_pkg.sv
// Shared sizing constants and types for the score digit sequencer.
// SCORE_W must be at least 16 so that hit_points fits in the accumulator.
package score_pkg;

  localparam int          NUM_DIGITS = 9;
  localparam int          SCORE_W    = 32;
  localparam int unsigned MAX_SCORE  = 32'd999_999_999;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } score_state_t;

  typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/score_digit_sequencer_bcd_add3.sv
// Double-dabble digit corrector: a BCD nibble of 5 or more gets +3 before the
// next left shift, so that the shift carries correctly into the next decade.
module bcd_add3
  import score_pkg::*;
(
  input  bcd_digit_t digit_i,
  output bcd_digit_t digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? bcd_digit_t'(digit_i + 4'd3) : digit_i;

endmodule

// File: rtl/score_digit_sequencer.sv
// Saturating score accumulator with a once-per-frame sequential binary-to-BCD
// conversion (shift-add-3, one bit per clock) feeding the score renderer.
module score_digit_sequencer #(
  parameter int                 SCORE_W    = score_pkg::SCORE_W,
  parameter int                 NUM_DIGITS = score_pkg::NUM_DIGITS,
  parameter logic [SCORE_W-1:0] MAX_SCORE  = SCORE_W'(score_pkg::MAX_SCORE)
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    frame_clk,
  input  logic                    clear,
  input  logic                    hit_valid,
  input  logic [15:0]             hit_points,
  output logic [SCORE_W-1:0]      score,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic                    digits_valid,
  output logic                    busy
);

  import score_pkg::*;

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(SCORE_W);

  score_state_t       state_q, state_d;
  logic               frame_clk_q;
  logic               rise;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W:0]   sum;
  logic [SCORE_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BCD_W-1:0]   bcd_adj;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   digits_q, digits_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;

  // frame_clk_q resets high so a frame_clk held high through reset is not an edge
  assign rise = frame_clk & ~frame_clk_q;

  assign sum = {1'b0, score_q} + {{(SCORE_W + 1 - 16){1'b0}}, hit_points};

  always_comb begin
    score_d = score_q;
    if (clear) begin
      score_d = '0;
    end else if (hit_valid) begin
      score_d = (sum > {1'b0, MAX_SCORE}) ? MAX_SCORE : sum[SCORE_W-1:0];
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit_i (bcd_q[4*g +: 4]),
      .digit_o (bcd_adj[4*g +: 4])
    );
  end

  // The snapshot is taken from score_q, so a same-cycle hit lands next frame
  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    digits_d = digits_q;
    valid_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (rise) begin
          bin_d   = score_q;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        bcd_d = {bcd_adj[BCD_W-2:0], bin_q[SCORE_W-1]};
        bin_d = {bin_q[SCORE_W-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(SCORE_W - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        digits_d = bcd_q;
        valid_d  = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= S_IDLE;
      frame_clk_q <= 1'b1;
      score_q     <= '0;
      bin_q       <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      digits_q    <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_clk_q <= frame_clk;
      score_q     <= score_d;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      cnt_q       <= cnt_d;
      digits_q    <= digits_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
    end
  end

  assign score        = score_q;
  assign digits_out   = digits_q;
  assign digits_valid = valid_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_score_digit_sequencer.sv
// Directed bench for score_digit_sequencer: table-driven accumulator vectors
// followed by hand-written frame conversion sequences.
module tb_score_digit_sequencer;

  logic        Clk;
  logic        Reset_n;
  logic        frame_clk;
  logic        clear;
  logic        hit_valid;
  logic [15:0] hit_points;
  logic [31:0] score;
  logic [35:0] digits_out;
  logic        digits_valid;
  logic        busy;

  int testsRun = 0;
  int testsFailed = 0;

  typedef struct {
    logic        clr;
    logic        hit;
    logic [15:0] pts;
    logic [31:0] expScore;
  } accVec_t;

  accVec_t vecs[11];

  score_digit_sequencer dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .frame_clk    (frame_clk),
    .clear        (clear),
    .hit_valid    (hit_valid),
    .hit_points   (hit_points),
    .score        (score),
    .digits_out   (digits_out),
    .digits_valid (digits_valid),
    .busy         (busy)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic applyStimulus(input logic clr, input logic hit, input logic [15:0] pts);
    clear      = clr;
    hit_valid  = hit;
    hit_points = pts;
    tick();
    clear      = 1'b0;
    hit_valid  = 1'b0;
    hit_points = 16'd0;
  endtask

  // Produces a frame_clk rise sampled at the returned edge (edge N).
  task automatic frameRise();
    frame_clk = 1'b0;
    tick();
    frame_clk = 1'b1;
    tick();
    frame_clk = 1'b0;
  endtask

  // midKind: 0 none, 1 hit of midPts at edge N+midCycle, 2 extra rise at N+midCycle
  task automatic runConversion(input string name, input logic [35:0] expDigits,
                               input int midKind, input int midCycle, input logic [15:0] midPts);
    int latency;
    int pulses;
    int busyLow;
    frameRise();
    latency = -1;
    pulses  = 0;
    busyLow = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (midKind == 1 && cyc == midCycle) begin
        hit_valid  = 1'b1;
        hit_points = midPts;
      end
      if (midKind == 2 && cyc == midCycle) frame_clk = 1'b1;
      tick();
      hit_valid  = 1'b0;
      hit_points = 16'd0;
      if (digits_valid) begin
        pulses++;
        if (latency < 0) begin
          latency = cyc;
          checkOutput({name, " digits"}, 64'(digits_out), 64'(expDigits));
        end
      end else if (latency < 0 && !busy) begin
        busyLow++;
      end
    end
    frame_clk = 1'b0;
    checkOutput({name, " latency"}, 64'(latency), 64'd33);
    checkOutput({name, " pulses"}, 64'(pulses), 64'd1);
    checkOutput({name, " busy gaps"}, 64'(busyLow), 64'd0);
    checkOutput({name, " digits hold"}, 64'(digits_out), 64'(expDigits));
  endtask

  initial begin
    int badBusy;
    int badValid;
    logic [31:0] model;

    Reset_n    = 1'b0;
    frame_clk  = 1'b0;
    clear      = 1'b0;
    hit_valid  = 1'b0;
    hit_points = 16'd0;

    vecs[0]  = '{1'b1, 1'b0, 16'd0,     32'd0};
    vecs[1]  = '{1'b0, 1'b1, 16'd65535, 32'd65535};
    vecs[2]  = '{1'b0, 1'b1, 16'd1,     32'd65536};
    vecs[3]  = '{1'b0, 1'b0, 16'd77,    32'd65536};
    vecs[4]  = '{1'b1, 1'b1, 16'd40,    32'd0};
    vecs[5]  = '{1'b0, 1'b1, 16'd300,   32'd300};
    vecs[6]  = '{1'b1, 1'b1, 16'd40,    32'd0};
    vecs[7]  = '{1'b0, 1'b1, 16'd0,     32'd0};
    vecs[8]  = '{1'b0, 1'b1, 16'd5,     32'd5};
    vecs[9]  = '{1'b0, 1'b1, 16'd20,    32'd25};
    vecs[10] = '{1'b0, 1'b0, 16'd0,     32'd25};

    tick();
    tick();
    checkOutput("reset score", 64'(score), 64'd0);
    checkOutput("reset digits", 64'(digits_out), 64'd0);
    checkOutput("reset valid", 64'(digits_valid), 64'd0);
    checkOutput("reset busy", 64'(busy), 64'd0);
    Reset_n = 1'b1;
    tick();

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].clr, vecs[i].hit, vecs[i].pts);
      checkOutput($sformatf("acc vec %0d", i), 64'(score), 64'(vecs[i].expScore));
    end

    runConversion("conv 25", 36'h000000025, 0, 0, 16'd0);

    applyStimulus(1'b0, 1'b1, 16'd275);
    checkOutput("score 300", 64'(score), 64'd300);
    applyStimulus(1'b1, 1'b1, 16'd40);
    checkOutput("clear wins", 64'(score), 64'd0);
    runConversion("conv cleared", 36'h000000000, 0, 0, 16'd0);

    model = 32'd0;
    for (int i = 0; i < 15259; i++) begin
      applyStimulus(1'b0, 1'b1, 16'd65535);
      model = model + 32'd65535;
    end
    applyStimulus(1'b0, 1'b1, 16'd1425);
    model = model + 32'd1425;
    checkOutput("score near max", 64'(score), 64'(model));
    checkOutput("score 999999990", 64'(score), 64'd999999990);
    applyStimulus(1'b0, 1'b1, 16'd50);
    checkOutput("saturate", 64'(score), 64'd999999999);
    applyStimulus(1'b0, 1'b1, 16'd65535);
    checkOutput("stay saturated", 64'(score), 64'd999999999);
    runConversion("conv max w/ 2nd rise", 36'h999999999, 2, 10, 16'd0);

    applyStimulus(1'b1, 1'b0, 16'd0);
    applyStimulus(1'b0, 1'b1, 16'd100);
    runConversion("conv snapshot 100", 36'h000000100, 1, 12, 16'd7);
    checkOutput("score 107", 64'(score), 64'd107);
    runConversion("conv 107", 36'h000000107, 0, 0, 16'd0);

    frameRise();
    for (int i = 0; i < 15; i++) tick();
    checkOutput("busy before reset", 64'(busy), 64'd1);
    frame_clk = 1'b1;
    Reset_n   = 1'b0;
    #2;
    checkOutput("abort busy", 64'(busy), 64'd0);
    checkOutput("abort digits", 64'(digits_out), 64'd0);
    checkOutput("abort valid", 64'(digits_valid), 64'd0);
    checkOutput("abort score", 64'(score), 64'd0);
    tick();
    Reset_n = 1'b1;
    badBusy  = 0;
    badValid = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (busy) badBusy++;
      if (digits_valid) badValid++;
    end
    checkOutput("no spurious busy", 64'(badBusy), 64'd0);
    checkOutput("no spurious valid", 64'(badValid), 64'd0);
    applyStimulus(1'b0, 1'b1, 16'd42);
    runConversion("conv after reset", 36'h000000042, 0, 0, 16'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/score_digit_sequencer.md
Name: score_digit_sequencer

Overview:
Owns the player score and turns it into the nine BCD digits that the score renderer uses as sprite-sheet indices. It accumulates hit points with saturation. Once per frame, on the rising edge of frame_clk, it snapshots the score and converts it to BCD sequentially using shift-add-3 (one bit per Clk), instead of a per-digit combinational divider. It publishes a stable, registered digit vector plus a one-cycle valid pulse, and sits between the game-state logic and the score display.

Parameters:
SCORE_W, 32, width of score accumulator and conversion shift register
NUM_DIGITS, 9, BCD digits produced (4 bits each)
MAX_SCORE, 999999999, saturation ceiling; must be < 10^NUM_DIGITS and < 2^SCORE_W

Ports:
Clk  in  1  50 MHz system clock
Reset_n  in  1  asynchronous, active-low reset
frame_clk  in  1  frame tick (~60 Hz), level signal sampled on Clk
clear  in  1  synchronous score clear (new game)
hit_valid  in  1  add hit_points to score this cycle
hit_points  in  16  points to add, unsigned
score  out  SCORE_W  current accumulated score, registered
digits_out  out  4*NUM_DIGITS  BCD digits; [3:0] = ones, [35:32] = 10^8 digit
digits_valid  out  1  one-cycle pulse when digits_out has just been updated
busy  out  1  high while a conversion is in progress

Behaviour:
- Reset (Reset_n low, async): score=0, digits_out=0, digits_valid=0, busy=0, FSM=IDLE, bit counter=0, frame_clk_d=1. Because frame_clk_d resets to 1, a frame_clk held high through reset release produces no spurious edge.
- Edge detect: frame_clk_d <= frame_clk every Clk. rise = frame_clk & ~frame_clk_d.
- Accumulator (independent of FSM), priority order:
  - clear: score <= 0. A simultaneous hit is discarded.
  - hit_valid: sum = score + zero-extended hit_points, computed in SCORE_W+1 bits. score <= (sum > MAX_SCORE) ? MAX_SCORE : sum.
  - otherwise score holds.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: on rise, bin_sr <= score (value of the score register in that cycle, before any same-cycle hit), bcd_sr <= 0, cnt <= 0, go to SHIFT. Without rise, stay in IDLE.
  - SHIFT: each cycle, every nibble of bcd_sr >= 5 gets +3. Then {bcd_sr, bin_sr} shifts left 1, MSB of bin_sr enters bcd_sr[0]. cnt increments. After the shift with cnt == SCORE_W-1, go to DONE.
  - DONE: digits_out <= bcd_sr, digits_valid <= 1 for exactly one cycle, go to IDLE.
- busy = 1 in SHIFT and DONE, registered with the state.
- Latency: if rise is sampled at Clk edge N, SHIFT spans edges N+1..N+SCORE_W. digits_out/digits_valid are updated at edge N+SCORE_W+1, which is 33 cycles after N at default.
- rise while busy: ignored, not queued. No more than one conversion per frame.
- hit or clear during conversion: updates score only. The in-flight snapshot is unaffected; the next frame reflects the change.
- digits_out holds its value between conversions. The display never sees partial results.
- Saturation guarantees the snapshot is ≤ MAX_SCORE, so the 4*NUM_DIGITS bcd_sr never overflows. Intermediate prefixes are ≤ the final value.
- Reset mid-conversion: aborts immediately, all outputs go to reset values, and no valid pulse is produced.

Decomposition:
- Package score_pkg holds:
  - NUM_DIGITS, SCORE_W, MAX_SCORE
  - typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} score_state_t
  - typedef logic [3:0] bcd_digit_t
- Sub-module bcd_add3: combinational 4-bit "if ≥5 add 3" corrector, instantiated NUM_DIGITS times via generate.

Test Plan:
- Reset, hits 5 then 20, then frame_clk rise → score=25. Exactly 33 cycles later digits_out=36'h000000025 and digits_valid high for 1 cycle; busy high for the preceding cycles.
- score=999999990, hit 50 → score=999999999 (saturated). Next frame → digits_out=36'h999999999.
- Second frame_clk rise 10 cycles into a conversion → only one digits_valid pulse; busy waveform unchanged.
- Snapshot score=100, hit 7 at SHIFT cycle 12 → digits_out=36'h000000100. Next frame → 36'h000000107.
- clear and hit_valid (points 40) in the same cycle with score=300 → score=0; the next conversion yields all-zero digits.
- Reset_n low at SHIFT cycle 15, frame_clk held high through release → busy=0, digits_out=0, and no conversion starts until frame_clk falls and rises again.
